// File: rtl/imc_wb_master.sv
// imc_wb_master: Wishbone classic-cycle initiator that turns a local command
// (start address, word count, direction) plus data streams into single-beat
// Wishbone transactions at incrementing word addresses. It loads the IMC
// buffers and drains the output buffer of the SRAM compute wrapper.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_*                   command handshake (valid/ready, write, addr, len)
//   wr_data/valid/ready     write-data stream into the initiator
//   rd_data/valid/ready     read-data stream out of the initiator
//   wbm_*                   Wishbone classic initiator port
//   busy, done, err         status; done/err are one-cycle pulses
module imc_wb_master #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_REQ, S_RHOLD, S_FIN, S_ABORT
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [15:0]      to_q;
  logic             wr_mode_q;
  logic             cmd_ready_q, wr_ready_q, rd_valid_q;
  logic             cyc_q, stb_q, we_q, done_q, err_q;
  logic [31:0]      adr_q, dat_q, rd_data_q;

  logic [31:0]      adr_d;
  logic [LEN_W-1:0] cnt_d;
  logic             last_d;

  // Word-address increment wraps naturally at the 32-bit boundary.
  assign adr_d  = adr_q + 32'd4;
  assign cnt_d  = cnt_q - LEN_W'(1);
  assign last_d = (cnt_q == LEN_W'(1));

  // Byte-offset bits of the start address are deliberately discarded.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
      wr_mode_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rd_data_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Ready re-asserts one cycle after returning here, so it never
          // overlaps the done/err pulse of the previous command.
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            wr_mode_q   <= cmd_write;
            adr_q       <= {cmd_addr[31:2], 2'b00};
            cnt_q       <= cmd_len;
            if (cmd_len == '0) begin
              state_q <= S_ABORT;
            end else if (cmd_write) begin
              state_q    <= S_WDATA;
              cyc_q      <= 1'b1;
              wr_ready_q <= 1'b1;
            end else begin
              state_q <= S_REQ;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= 1'b0;
              to_q    <= '0;
            end
          end
        end
        S_WDATA: begin
          if (wr_valid) begin
            dat_q      <= wr_data;
            wr_ready_q <= 1'b0;
            stb_q      <= 1'b1;
            we_q       <= 1'b1;
            to_q       <= '0;
            state_q    <= S_REQ;
          end
        end
        S_REQ: begin
          // stb is always high here, so ack is only honoured while strobing.
          // Ack is checked before the timeout so a last-cycle ack succeeds.
          if (wbm_ack_i) begin
            stb_q <= 1'b0;
            if (wr_mode_q) begin
              cnt_q <= cnt_d;
              if (last_d) begin
                cyc_q   <= 1'b0;
                we_q    <= 1'b0;
                state_q <= S_FIN;
              end else begin
                adr_q      <= adr_d;
                wr_ready_q <= 1'b1;
                state_q    <= S_WDATA;
              end
            end else begin
              rd_data_q  <= wbm_dat_i;
              rd_valid_q <= 1'b1;
              state_q    <= S_RHOLD;
            end
          end else if (to_q == 16'(TIMEOUT - 1)) begin
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_ABORT;
          end else begin
            to_q <= to_q + 16'd1;
          end
        end
        S_RHOLD: begin
          if (rd_ready) begin
            rd_valid_q <= 1'b0;
            cnt_q      <= cnt_d;
            if (last_d) begin
              cyc_q   <= 1'b0;
              state_q <= S_FIN;
            end else begin
              adr_q   <= adr_d;
              stb_q   <= 1'b1;
              to_q    <= '0;
              state_q <= S_REQ;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        S_ABORT: begin
          err_q      <= 1'b1;
          cyc_q      <= 1'b0;
          stb_q      <= 1'b0;
          we_q       <= 1'b0;
          rd_valid_q <= 1'b0;
          wr_ready_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imc_wb_master.sv
module tb_imc_wb_master;
  localparam int LEN_W = 8;
  localparam int TO    = 8;

  logic clk = 1'b0, reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0] wr_data = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [31:0] rd_data;
  logic rd_valid, rd_ready = 1'b1;
  logic wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0] wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic wbm_ack_i;
  logic busy, done, err;

  int n_tests = 0, n_fail = 0;

  // Scoreboard queues
  logic [31:0] q_adr[$], q_dat[$], q_rd[$];

  // Responder model: registered ack one cycle after stb, data from address.
  logic slave_en = 1'b1;
  logic [31:0] rd_base = '0, rd_adr0 = '0;

  imc_wb_master #(.LEN_W(LEN_W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbm_ack_i <= 1'b0;
      wbm_dat_i <= '0;
    end else begin
      wbm_ack_i <= wbm_stb_o & ~wbm_ack_i & slave_en;
      if (wbm_stb_o & ~wbm_ack_i & slave_en & ~wbm_we_o)
        wbm_dat_i <= rd_base + ((wbm_adr_o - rd_adr0) >> 2);
    end
  end

  // Drives a command; returns at #1 after the accepting edge.
  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [LEN_W-1:0] l);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    for (int i = 0; i < 50 && !cmd_ready; i++) begin @(posedge clk); #1; end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, done, err, wr_ready, rd_valid} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, done, err, wr_ready, rd_valid});
    end
    n_tests++;
    if ({rd_data, wbm_adr_o, wbm_dat_o} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: rd=%h adr=%h dat=%h required 0", rd_data, wbm_adr_o, wbm_dat_o);
    end
    n_tests++;
    if (wbm_sel_o !== 4'hF) begin
      n_fail++; $display("FAIL reset_sel: got %h required f", wbm_sel_o);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: cmd_ready=%0b busy=%0b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write(input logic [31:0] base, input int len);
    int k, beats, cyc_rise, stb_rise, err_seen, done_seen;
    logic prev_cyc, prev_stb, prev_ack, consumed;
    logic [31:0] ea, ed;
    k = 0; beats = 0; cyc_rise = 0; stb_rise = 0; err_seen = 0; done_seen = 0;
    prev_cyc = 0; prev_stb = 0; prev_ack = 0; consumed = 0;
    q_adr.delete(); q_dat.delete();
    wr_valid = 1'b1; wr_data = $urandom;
    send_cmd(1'b1, base, LEN_W'(len));
    for (int c = 0; c < 300 && done_seen == 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (consumed) begin wr_data = $urandom; consumed = 0; end
      if (wbm_cyc_o && !prev_cyc) cyc_rise++;
      if (wbm_stb_o && !prev_stb) stb_rise++;
      if (prev_ack) begin
        n_tests++;
        if (wbm_stb_o !== 1'b0) begin
          n_fail++; $display("FAIL wr_stb_gap: stb=%0b required 0 after ack", wbm_stb_o);
        end
      end
      if (wbm_stb_o && wbm_ack_i) begin
        n_tests++; beats++;
        if (q_adr.size() == 0) begin
          n_fail++; $display("FAIL wr_beat_extra: adr=%h with empty scoreboard", wbm_adr_o);
        end else begin
          ea = q_adr.pop_front(); ed = q_dat.pop_front();
          if (wbm_adr_o !== ea || wbm_dat_o !== ed || wbm_we_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_beat: adr=%h dat=%h we=%0b required adr=%h dat=%h we=1",
                     wbm_adr_o, wbm_dat_o, wbm_we_o, ea, ed);
          end
        end
      end
      if (wr_valid && wr_ready) begin
        q_adr.push_back(base + 32'(k * 4));
        q_dat.push_back(wr_data);
        k++; consumed = 1;
      end
      if (err) err_seen++;
      if (done) done_seen++;
      prev_cyc = wbm_cyc_o; prev_stb = wbm_stb_o; prev_ack = wbm_stb_o & wbm_ack_i;
    end
    wr_valid = 1'b0;
    n_tests++;
    if (done_seen != 1 || err_seen != 0) begin
      n_fail++; $display("FAIL wr_done: done=%0d err=%0d required 1/0", done_seen, err_seen);
    end
    n_tests++;
    if (beats != len || stb_rise != len || k != len) begin
      n_fail++; $display("FAIL wr_count: beats=%0d stb_rises=%0d words=%0d required %0d",
                         beats, stb_rise, k, len);
    end
    n_tests++;
    if (cyc_rise != 1) begin
      n_fail++; $display("FAIL wr_cyc_cont: cyc rises=%0d required 1", cyc_rise);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL wr_done_pulse: done=%0b cyc=%0b required 0/0", done, wbm_cyc_o);
    end
  endtask

  task automatic test_read();
    int beat, w, wcnt, hold, stb_rise, done_seen, stb_in_hold, unstable;
    logic prev_stb;
    logic [31:0] held, er, ea;
    beat = 0; w = 0; wcnt = 0; hold = 0; stb_rise = 0; done_seen = 0;
    stb_in_hold = 0; unstable = 0; prev_stb = 0; held = '0;
    rd_base = 32'hA5A5_0001; rd_adr0 = 32'h3000_0100;
    q_rd.delete();
    for (int i = 0; i < 3; i++) q_rd.push_back(32'hA5A5_0001 + 32'(i));
    rd_ready = 1'b1;
    send_cmd(1'b0, 32'h3000_0100, LEN_W'(3));
    for (int c = 0; c < 300 && done_seen == 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (wbm_stb_o && !prev_stb) stb_rise++;
      if (wbm_stb_o && rd_valid) stb_in_hold++;
      if (wbm_stb_o && wbm_ack_i) begin
        n_tests++;
        ea = 32'h3000_0100 + 32'(beat * 4);
        if (wbm_adr_o !== ea || wbm_we_o !== 1'b0) begin
          n_fail++; $display("FAIL rd_adr: adr=%h we=%0b required %h/0", wbm_adr_o, wbm_we_o, ea);
        end
        beat++;
      end
      if (rd_valid) begin
        if (w == 1) begin
          wcnt++;
          if (wcnt == 1) held = rd_data;
          else if (rd_data !== held) unstable++;
        end
        if (w == 1 && hold < 5) begin rd_ready = 1'b0; hold++; end
        else rd_ready = 1'b1;
        if (rd_ready) begin
          n_tests++;
          er = (q_rd.size() != 0) ? q_rd.pop_front() : 32'hDEAD_BEEF;
          if (rd_data !== er) begin
            n_fail++; $display("FAIL rd_data: got %h required %h", rd_data, er);
          end
          w++;
        end
      end else begin
        rd_ready = 1'b1;
      end
      if (done) done_seen++;
      prev_stb = wbm_stb_o;
    end
    rd_ready = 1'b1;
    n_tests++;
    if (done_seen != 1 || w != 3) begin
      n_fail++; $display("FAIL rd_done: done=%0d words=%0d required 1/3", done_seen, w);
    end
    n_tests++;
    if (wcnt != 6 || unstable != 0 || held !== 32'hA5A5_0002) begin
      n_fail++; $display("FAIL rd_hold: valid_cycles=%0d unstable=%0d data=%h required 6/0/a5a50002",
                         wcnt, unstable, held);
    end
    n_tests++;
    if (stb_rise != 3 || stb_in_hold != 0) begin
      n_fail++; $display("FAIL rd_stb: rises=%0d during_hold=%0d required 3/0", stb_rise, stb_in_hold);
    end
  endtask

  task automatic test_timeout();
    int stb_hi, err_at, done_seen;
    logic prev_stb;
    stb_hi = 0; err_at = -1; done_seen = 0; prev_stb = 0;
    slave_en = 1'b0;
    send_cmd(1'b0, 32'h3000_0200, LEN_W'(1));
    for (int c = 0; c < 40 && err_at < 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (wbm_stb_o) stb_hi++;
      if (prev_stb && !wbm_stb_o) begin
        n_tests++;
        if (wbm_cyc_o !== 1'b0) begin
          n_fail++; $display("FAIL to_cyc_drop: cyc=%0b required 0", wbm_cyc_o);
        end
      end
      if (done) done_seen++;
      if (err) err_at = c;
      prev_stb = wbm_stb_o;
    end
    n_tests++;
    if (stb_hi != TO) begin
      n_fail++; $display("FAIL to_stb_len: stb cycles=%0d required %0d", stb_hi, TO);
    end
    n_tests++;
    if (err_at < 0 || done_seen != 0) begin
      n_fail++; $display("FAIL to_err: err_at=%0d done=%0d required err and no done", err_at, done_seen);
    end
    @(posedge clk); #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL to_ready: cmd_ready=%0b err=%0b required 1/0", cmd_ready, err);
    end
    slave_en = 1'b1;
  endtask

  task automatic test_zero_len();
    int err_at, err_cnt, cyc_seen, done_seen;
    err_at = -1; err_cnt = 0; cyc_seen = 0; done_seen = 0;
    send_cmd(1'b1, 32'h3000_0300, LEN_W'(0));
    // Cycle index 1 is the first cycle after the accepting edge.
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (wbm_cyc_o) cyc_seen++;
      if (done) done_seen++;
      if (err) begin err_cnt++; if (err_at < 0) err_at = i; end
    end
    n_tests++;
    if (err_at != 2 || err_cnt != 1) begin
      n_fail++; $display("FAIL zl_err: first at cycle %0d count %0d required 2/1", err_at, err_cnt);
    end
    n_tests++;
    if (cyc_seen != 0 || done_seen != 0) begin
      n_fail++; $display("FAIL zl_bus: cyc cycles=%0d done=%0d required 0/0", cyc_seen, done_seen);
    end
  endtask

  task automatic test_reset_mid();
    int found, bad;
    found = 0; bad = 0;
    wr_valid = 1'b1; wr_data = 32'h1234_5678;
    send_cmd(1'b1, 32'h3000_0400, LEN_W'(5));
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (wbm_stb_o && wbm_adr_o == 32'h3000_0408) found = 1;
    end
    n_tests++;
    if (found == 0) begin
      n_fail++; $display("FAIL rm_reach: word 3 strobe not seen, found=%0d required 1", found);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({wbm_cyc_o, wbm_stb_o, busy, done, err, wr_ready} !== 6'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rm_async: cyc/stb/busy/done/err/wr_ready=%b ready=%0b required 000000/1",
                         {wbm_cyc_o, wbm_stb_o, busy, done, err, wr_ready}, cmd_ready);
    end
    wr_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done || err || wbm_cyc_o) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rm_quiet: %0d cycles with done/err/cyc required 0", bad);
    end
    test_write(32'h3000_0500, 1);
  endtask

  initial begin
    test_reset();
    test_write(32'h3000_0000, 4);
    test_read();
    test_timeout();
    test_zero_len();
    test_write(32'hFFFF_FFFC, 2);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
